pe_psum_accumulator: RTL and testbench
======================================

// Module: pe_psum_accumulator
// PURPOSE
//  Accumulation stage directly downstream of the PE multiplier. Sums a configured number of signed
//  products into one partial sum, optionally adds the psum arriving from the neighbouring PE, and
//  hands the result onward over a valid/ready link. One instance per PE.
// PARAMETERS
//  DATA_WIDTH  16  operand width; the product input is 2*DATA_WIDTH bits, signed
//  GUARD_BITS  4   extra accumulator bits; ACC_WIDTH = 2*DATA_WIDTH+GUARD_BITS
//  PSUM_WIDTH  32  width of psum_in / psum_out, signed
//  LEN_WIDTH   8   width of cfg_len
// PORTS
//  clk             in   1           clock; all state updates on posedge
//  reset_n         in   1           asynchronous, active-low reset
//  start           in   1           begin a new psum; sampled only in IDLE, or in DONE on a completing handshake
//  cfg_len         in   LEN_WIDTH   products per psum, latched on start; 0 is treated as 1
//  cfg_psum_in_en  in   1           latched on start; 1 = add psum_in before output
//  product_valid   in   1           product is valid this cycle (multiplier enable, delayed)
//  product         in   2*DATA_WIDTH signed product from the multiplier (registered on negedge)
//  psum_in_valid   in   1           upstream psum valid
//  psum_in_ready   out  1           psum_in accepted when valid&&ready
//  psum_in         in   PSUM_WIDTH  signed incoming psum
//  psum_out_valid  out  1           result valid
//  psum_out_ready  in   1           downstream accepts the result
//  psum_out        out  PSUM_WIDTH  signed result, narrowed from ACC_WIDTH
//  busy            out  1           state != IDLE
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - state=IDLE, acc=0, cnt=0.
//    - psum_out=0, psum_out_valid=0, psum_in_ready=0, busy=0.
//    - A reset mid-operation discards the in-flight psum; nothing is emitted for it.
//  - FSM: IDLE -> ACCUM -> (MERGE if psum_in_en) -> DONE -> IDLE.
//  - IDLE:
//    - On start: latch len = (cfg_len==0 ? 1 : cfg_len) and psum_in_en; clear acc and cnt; go to ACCUM.
//    - product_valid is ignored in IDLE.
//  - ACCUM:
//    - Each cycle with product_valid=1: acc += sign-extend(product); cnt += 1.
//    - Cycles with product_valid=0 hold acc and cnt; there is no timeout.
//    - When the product taking cnt to len is accepted: go to MERGE if psum_in_en, else to DONE.
//  - MERGE:
//    - psum_in_ready=1 (combinational from state).
//    - On psum_in_valid: acc += sign-extend(psum_in); go to DONE.
//    - product_valid is ignored.
//  - DONE:
//    - psum_out_valid=1; psum_out = narrow(acc), registered and held stable until accepted.
//    - On psum_out_ready: go to IDLE.
//    - If start is also high that cycle, go straight to ACCUM with new config (back-to-back, no bubble).
//    - start without ready in DONE is ignored.
//  - Latency: psum_out_valid rises on the cycle after the last product is accepted (no merge), or after psum_in is accepted.
//  - Arithmetic: two's complement throughout. acc wraps at ACC_WIDTH; GUARD_BITS sizes it to hold 2^GUARD_BITS full-scale products without overflow.
//  - start held high in ACCUM or MERGE has no effect.
// CONFIGURATION
//  - PSUM_SATURATION_EN defined: narrow() clamps acc to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1].
//  - PSUM_SATURATION_EN undefined: narrow() = acc[PSUM_WIDTH-1:0] (wrap).
//  - In both cases acc itself always wraps at ACC_WIDTH; the macro affects only narrowing.
// STRUCTURE
//  - pe_pkg: state enum acc_state_t {IDLE, ACCUM, MERGE, DONE}; default width constants.
//  - Sub-module pe_psum_narrow: combinational ACC_WIDTH -> PSUM_WIDTH narrowing; the only logic under PSUM_SATURATION_EN.
// TESTING
//  1. len=3, psum_in_en=0, products 10,-4,7 with one idle cycle between -> psum_out=13, valid one cycle after the 3rd product.
//  2. len=2, psum_in_en=1, products 100,200; psum_in=-50 sent 3 cycles late -> psum_in_ready held until accepted, then psum_out=250.
//  3. len=16, 16 products of 32767*32767 -> SAT: psum_out=0x7FFFFFFF; no SAT: 0xFFF00010.
//  4. cfg_len=0, one product -5 -> psum_out=-5 (0xFFFFFFFB).
//  5. psum_out_ready low 4 cycles, then high with start=1, len=1, product 9 -> first psum stable throughout; next psum_out=9, no bubble.
//  6. reset_n low mid-ACCUM after 2 of 4 products -> all outputs 0, IDLE; a new run with len=1, product 3 -> psum_out=3.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and default widths for the PE partial-sum accumulation stage.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        MERGE = 2'd2,
        DONE  = 2'd3
    } acc_state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_GUARD_BITS = 4;
    localparam int DEFAULT_PSUM_WIDTH = 32;
    localparam int DEFAULT_LEN_WIDTH  = 8;

endpackage

// File: rtl/pe_psum_narrow.sv
// Combinational ACC_WIDTH -> PSUM_WIDTH narrowing of the accumulator.
// PSUM_SATURATION_EN selects clamping; otherwise the upper bits are dropped (wrap).
module pe_psum_narrow
    import pe_pkg::*;
#(
    parameter int ACC_WIDTH  = 2*DEFAULT_DATA_WIDTH + DEFAULT_GUARD_BITS,
    parameter int PSUM_WIDTH = DEFAULT_PSUM_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [PSUM_WIDTH-1:0] narrowed
);

    generate
        if (ACC_WIDTH > PSUM_WIDTH) begin : g_reduce
`ifdef PSUM_SATURATION_EN
            logic [ACC_WIDTH-PSUM_WIDTH:0] top_bits_s;
            logic                          in_range_s;

            assign top_bits_s = acc[ACC_WIDTH-1:PSUM_WIDTH-1];
            // In range when every bit above the result's sign bit matches it.
            assign in_range_s = (top_bits_s == {(ACC_WIDTH-PSUM_WIDTH+1){1'b0}}) ||
                                (top_bits_s == {(ACC_WIDTH-PSUM_WIDTH+1){1'b1}});

            // Clamp toward the sign of the accumulator when it does not fit.
            always_comb begin
                narrowed = acc[PSUM_WIDTH-1:0];
                if (in_range_s) begin
                    narrowed = acc[PSUM_WIDTH-1:0];
                end else if (acc[ACC_WIDTH-1]) begin
                    narrowed = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
                end else begin
                    narrowed = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
                end
            end
`else
            assign narrowed = acc[PSUM_WIDTH-1:0];
`endif
        end else begin : g_extend
            assign narrowed = PSUM_WIDTH'(acc);
        end
    endgenerate

endmodule

// File: rtl/pe_psum_accumulator.sv
// Per-PE partial-sum accumulator: sums cfg_len signed products, optionally merges the
// neighbour psum, and emits over valid/ready. Optional macro: PSUM_SATURATION_EN.
module pe_psum_accumulator
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int GUARD_BITS = DEFAULT_GUARD_BITS,
    parameter int PSUM_WIDTH = DEFAULT_PSUM_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           cfg_len,
    input  logic                           cfg_psum_in_en,
    input  logic                           product_valid,
    input  logic signed [2*DATA_WIDTH-1:0] product,
    input  logic                           psum_in_valid,
    output logic                           psum_in_ready,
    input  logic signed [PSUM_WIDTH-1:0]   psum_in,
    output logic                           psum_out_valid,
    input  logic                           psum_out_ready,
    output logic signed [PSUM_WIDTH-1:0]   psum_out,
    output logic                           busy
);

    localparam int ACC_WIDTH = 2*DATA_WIDTH + GUARD_BITS;

    acc_state_t                  state_r, state_next_s;
    logic signed [ACC_WIDTH-1:0] acc_r, acc_next_s;
    logic [LEN_WIDTH-1:0]        cnt_r, cnt_next_s, cnt_inc_s;
    logic [LEN_WIDTH-1:0]        len_r, len_next_s, cfg_len_eff_s;
    logic                        psum_in_en_r, psum_in_en_next_s;
    logic                        load_out_s;
    logic signed [PSUM_WIDTH-1:0] narrow_s;
    logic signed [PSUM_WIDTH-1:0] psum_out_r;

    assign cnt_inc_s     = cnt_r + LEN_WIDTH'(1);
    assign cfg_len_eff_s = (cfg_len == {LEN_WIDTH{1'b0}}) ? LEN_WIDTH'(1) : cfg_len;

    // Next-state, accumulator and counter update logic.
    always_comb begin
        state_next_s      = state_r;
        acc_next_s        = acc_r;
        cnt_next_s        = cnt_r;
        len_next_s        = len_r;
        psum_in_en_next_s = psum_in_en_r;
        load_out_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    len_next_s        = cfg_len_eff_s;
                    psum_in_en_next_s = cfg_psum_in_en;
                    acc_next_s        = {ACC_WIDTH{1'b0}};
                    cnt_next_s        = {LEN_WIDTH{1'b0}};
                    state_next_s      = ACCUM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (product_valid) begin
                    acc_next_s = acc_r + ACC_WIDTH'(product);
                    cnt_next_s = cnt_inc_s;
                    if (cnt_inc_s == len_r) begin
                        state_next_s = psum_in_en_r ? MERGE : DONE;
                        load_out_s   = !psum_in_en_r;
                    end else begin
                        state_next_s = ACCUM;
                    end
                end else begin
                    state_next_s = ACCUM;
                end
            end
            MERGE: begin
                if (psum_in_valid) begin
                    acc_next_s   = acc_r + ACC_WIDTH'(psum_in);
                    state_next_s = DONE;
                    load_out_s   = 1'b1;
                end else begin
                    state_next_s = MERGE;
                end
            end
            DONE: begin
                if (psum_out_ready && start) begin
                    // Back-to-back: the next psum starts in the handshake cycle.
                    len_next_s        = cfg_len_eff_s;
                    psum_in_en_next_s = cfg_psum_in_en;
                    acc_next_s        = {ACC_WIDTH{1'b0}};
                    cnt_next_s        = {LEN_WIDTH{1'b0}};
                    state_next_s      = ACCUM;
                end else if (psum_out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    pe_psum_narrow #(
        .ACC_WIDTH  (ACC_WIDTH),
        .PSUM_WIDTH (PSUM_WIDTH)
    ) u_narrow (
        .acc      (acc_next_s),
        .narrowed (narrow_s)
    );

    // State, datapath and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            acc_r        <= {ACC_WIDTH{1'b0}};
            cnt_r        <= {LEN_WIDTH{1'b0}};
            len_r        <= LEN_WIDTH'(1);
            psum_in_en_r <= 1'b0;
            psum_out_r   <= {PSUM_WIDTH{1'b0}};
        end else begin
            state_r      <= state_next_s;
            acc_r        <= acc_next_s;
            cnt_r        <= cnt_next_s;
            len_r        <= len_next_s;
            psum_in_en_r <= psum_in_en_next_s;
            if (load_out_s) begin
                psum_out_r <= narrow_s;
            end
        end
    end

    assign psum_out       = psum_out_r;
    assign psum_out_valid = (state_r == DONE);
    assign psum_in_ready  = (state_r == MERGE);
    assign busy           = (state_r != IDLE);

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Directed self-checking bench for pe_psum_accumulator (default widths).
// Expected results follow PSUM_SATURATION_EN when it is defined for the build.
module tb_pe_psum_accumulator;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  cfg_len;
    logic        cfg_psum_in_en;
    logic        product_valid;
    logic [31:0] product;
    logic        psum_in_valid;
    logic        psum_in_ready;
    logic [31:0] psum_in;
    logic        psum_out_valid;
    logic        psum_out_ready;
    logic [31:0] psum_out;
    logic        busy;

    int n_checks;
    int n_fail;

    pe_psum_accumulator dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .cfg_len        (cfg_len),
        .cfg_psum_in_en (cfg_psum_in_en),
        .product_valid  (product_valid),
        .product        (product),
        .psum_in_valid  (psum_in_valid),
        .psum_in_ready  (psum_in_ready),
        .psum_in        (psum_in),
        .psum_out_valid (psum_out_valid),
        .psum_out_ready (psum_out_ready),
        .psum_out       (psum_out),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; outputs are then sampled and inputs changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_product(input logic [31:0] p);
        product_valid = 1'b1;
        product       = p;
        tick();
        product_valid = 1'b0;
    endtask

    task automatic begin_run(input logic [7:0] len, input logic en);
        start          = 1'b1;
        cfg_len        = len;
        cfg_psum_in_en = en;
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        psum_out_ready = 1'b1;
        tick();
        psum_out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_sat;
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        start          = 1'b0;
        cfg_len        = 8'd0;
        cfg_psum_in_en = 1'b0;
        product_valid  = 1'b0;
        product        = 32'd0;
        psum_in_valid  = 1'b0;
        psum_in        = 32'd0;
        psum_out_ready = 1'b0;

        #7;
        check("rst_valid", 64'(psum_out_valid), 64'd0);
        check("rst_ready", 64'(psum_in_ready), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_out",   64'(psum_out), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // products are ignored while idle
        product_valid = 1'b1;
        product       = 32'd77;
        tick();
        product_valid = 1'b0;
        check("idle_ignore_busy", 64'(busy), 64'd0);

        // Test 1: len 3, gap cycle, start held high during ACCUM
        begin_run(8'd3, 1'b0);
        check("t1_busy", 64'(busy), 64'd1);
        start = 1'b1;
        put_product(32'd10);
        start = 1'b0;
        tick();
        put_product(-32'sd4);
        check("t1_not_yet", 64'(psum_out_valid), 64'd0);
        put_product(32'd7);
        check("t1_valid", 64'(psum_out_valid), 64'd1);
        check("t1_out",   64'(psum_out), 64'd13);
        drain();
        check("t1_idle_valid", 64'(psum_out_valid), 64'd0);
        check("t1_idle_busy",  64'(busy), 64'd0);

        // Test 2: merge with psum_in arriving 3 cycles late
        begin_run(8'd2, 1'b1);
        put_product(32'd100);
        put_product(32'd200);
        check("t2_in_ready", 64'(psum_in_ready), 64'd1);
        check("t2_no_valid", 64'(psum_out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            product_valid = 1'b1;
            product       = 32'd999;
            tick();
            check("t2_wait_ready", 64'(psum_in_ready), 64'd1);
        end
        product_valid = 1'b0;
        psum_in_valid = 1'b1;
        psum_in       = -32'sd50;
        tick();
        psum_in_valid = 1'b0;
        check("t2_valid",    64'(psum_out_valid), 64'd1);
        check("t2_ready_lo", 64'(psum_in_ready), 64'd0);
        check("t2_out",      64'(psum_out), 64'd250);
        drain();

        // Test 3: 16 full-scale products overflow the result width
        begin_run(8'd16, 1'b0);
        for (int i = 0; i < 16; i++) begin
            put_product(32'h3FFF0001);
        end
`ifdef PSUM_SATURATION_EN
        exp_sat = 32'h7FFFFFFF;
`else
        exp_sat = 32'hFFF00010;
`endif
        check("t3_valid", 64'(psum_out_valid), 64'd1);
        check("t3_out",   64'(psum_out), 64'(exp_sat));
        drain();

        // Test 4: cfg_len 0 behaves as 1
        begin_run(8'd0, 1'b0);
        put_product(-32'sd5);
        check("t4_valid", 64'(psum_out_valid), 64'd1);
        check("t4_out",   64'(psum_out), 64'hFFFFFFFB);

        // Test 5: backpressure, start without ready ignored, then back-to-back start
        for (int i = 0; i < 4; i++) begin
            start   = (i >= 2);
            cfg_len = 8'd1;
            tick();
            check("t5_hold_valid", 64'(psum_out_valid), 64'd1);
            check("t5_hold_out",   64'(psum_out), 64'hFFFFFFFB);
        end
        start          = 1'b1;
        cfg_len        = 8'd1;
        cfg_psum_in_en = 1'b0;
        psum_out_ready = 1'b1;
        tick();
        start          = 1'b0;
        psum_out_ready = 1'b0;
        check("t5_b2b_busy",  64'(busy), 64'd1);
        check("t5_b2b_valid", 64'(psum_out_valid), 64'd0);
        put_product(32'd9);
        check("t5_valid", 64'(psum_out_valid), 64'd1);
        check("t5_out",   64'(psum_out), 64'd9);
        drain();

        // Test 6: asynchronous reset mid-ACCUM
        begin_run(8'd4, 1'b0);
        put_product(32'd11);
        put_product(32'd12);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy",  64'(busy), 64'd0);
        check("t6_rst_valid", 64'(psum_out_valid), 64'd0);
        check("t6_rst_out",   64'(psum_out), 64'd0);
        check("t6_rst_ready", 64'(psum_in_ready), 64'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check("t6_no_emit", 64'(psum_out_valid), 64'd0);
        begin_run(8'd1, 1'b0);
        put_product(32'd3);
        check("t6_valid", 64'(psum_out_valid), 64'd1);
        check("t6_out",   64'(psum_out), 64'd3);
        drain();
        check("t6_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
